// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl
//   Command-driven up/down counter controller. A command is accepted in IDLE
//   when cmd_valid && cmd_ready. A clear command zeroes the counter, a zero
//   length command does nothing, and any other command runs the counter up or
//   down by cmd_len single steps, one per clock. Every command ends with a
//   single DONE cycle, and the controller then returns to IDLE.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset (overrides everything)
//   cmd_valid  command offered
//   cmd_ready  high only in IDLE
//   cmd_dir    1 = up, 0 = down (latched at accept)
//   cmd_len    number of steps (latched at accept)
//   cmd_clr    clear counter instead of counting
//   cnt_q      registered counter value
//   busy       state != IDLE
//   done       one-cycle completion pulse (registered)
//   wrap       one-cycle wrap-around pulse (registered)
module updown_count_ctrl #(
  parameter int CNT_W = 3,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_clr,
  output logic [CNT_W-1:0] cnt_q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_rem;
  logic               r_dir;
  logic               r_done;
  logic               r_wrap;

  logic               w_accept;
  logic               w_last_step;
  logic [CNT_W-1:0]   w_cnt_step;
  logic               w_wrap_step;

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_last_step = (r_rem == LEN_W'(1));

  // One counter step in the latched direction; the wrap flag is detected on
  // the value before the step (all-ones going up, zero going down).
  assign w_cnt_step  = r_dir ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
  assign w_wrap_step = r_dir ? (&r_cnt) : ~(|r_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_clr || (cmd_len == '0)) w_state_nxt = S_DONE;
          else                            w_state_nxt = S_RUN;
        end
      end
      S_RUN:   if (w_last_step) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
  end

  // Datapath: counter, remaining steps, latched direction and pulse flags.
  // done/wrap default low so each event produces exactly one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dir  <= 1'b0;
      r_done <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd_clr) begin
              r_cnt  <= '0;
              r_done <= 1'b1;
            end else if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rem <= cmd_len;
              r_dir <= cmd_dir;
            end
          end
        end
        S_RUN: begin
          r_cnt  <= w_cnt_step;
          r_rem  <= r_rem - 1'b1;
          r_wrap <= w_wrap_step;
          if (w_last_step) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cnt_q = r_cnt;
  assign done  = r_done;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_updown_count_ctrl.sv
module tb_updown_count_ctrl;
  localparam int CW = 3;
  localparam int LW = 4;
  localparam int M  = 1 << CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [LW-1:0] cmd_len;
  logic          cmd_clr;
  logic [CW-1:0] cnt_q;
  logic          busy;
  logic          done;
  logic          wrap;

  int n_chk  = 0;
  int n_pass = 0;

  updown_count_ctrl #(.CNT_W(CW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_clr(cmd_clr),
    .cnt_q(cnt_q), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Model: on accept, the whole future output trace of the command is laid
  // out in a queue, one entry per clock edge; an empty queue means idle.
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic          wrap;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   m_on = 0;

  function automatic exp_t mk(int c, bit b, bit d, bit w);
    exp_t r;
    r.cnt = CW'(c); r.busy = b; r.done = d; r.wrap = w;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e    = mk(0, 0, 0, 0);
      m_on = 1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end else if (cmd_valid) begin
      int c;
      c = int'(e.cnt);
      if (cmd_clr) begin
        q.push_back(mk(0, 1, 1, 0));
        q.push_back(mk(0, 0, 0, 0));
      end else if (cmd_len == 0) begin
        q.push_back(mk(c, 1, 1, 0));
        q.push_back(mk(c, 0, 0, 0));
      end else begin
        q.push_back(mk(c, 1, 0, 0));
        for (int k = 1; k <= int'(cmd_len); k++) begin
          int  nc;
          bit  w;
          nc = cmd_dir ? (c + 1) % M : (c + M - 1) % M;
          w  = cmd_dir ? (c == M - 1) : (c == 0);
          q.push_back(mk(nc, 1, k == int'(cmd_len), w));
          c = nc;
        end
        q.push_back(mk(c, 0, 0, 0));
      end
      e = q.pop_front();
    end else begin
      e.busy = 0; e.done = 0; e.wrap = 0;
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("cyc_cnt",   int'(cnt_q),     int'(e.cnt));
      chk("cyc_busy",  int'(busy),      int'(e.busy));
      chk("cyc_ready", int'(cmd_ready), int'(!e.busy));
      chk("cyc_done",  int'(done),      int'(e.done));
      chk("cyc_wrap",  int'(wrap),      int'(e.wrap));
    end
  end

  // Present one command once the DUT is ready; returns at the negedge after
  // the accepting edge.
  task automatic send(bit d, int len, bit c);
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("send_timeout", 0, 1);
    cmd_valid = 1; cmd_dir = d; cmd_len = LW'(len); cmd_clr = c;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic go(bit d, int len, bit c);
    send(d, len, c);
    wait_idle();
  endtask

  int len_tbl[8] = '{2, 5, 7, 1, 3, 9, 4, 6};

  initial begin
    // Reset with a command offered on the reset edges: must be discarded
    rst = 1; cmd_valid = 1; cmd_dir = 1; cmd_len = 3; cmd_clr = 0;
    repeat (2) @(negedge clk);
    chk("rst_cnt", cnt_q, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 0; cmd_valid = 0;
    @(negedge clk);

    // Up 3 from 0
    send(1, 3, 0);
    chk("up3_busy_e0", busy, 1);
    @(negedge clk); chk("up3_c1", cnt_q, 1);
    @(negedge clk); chk("up3_c2", cnt_q, 2);
    @(negedge clk); chk("up3_c3", cnt_q, 3); chk("up3_done", done, 1);
    chk("up3_busy_done", busy, 1);
    @(negedge clk); chk("up3_ready", cmd_ready, 1); chk("up3_done_off", done, 0);

    // To 6, then up 4 through the wrap
    go(1, 3, 0);
    send(1, 4, 0);
    chk("up4_c0", cnt_q, 6);
    @(negedge clk); chk("up4_c1", cnt_q, 7); chk("up4_w1", wrap, 0);
    @(negedge clk); chk("up4_c2", cnt_q, 0); chk("up4_w2", wrap, 1);
    @(negedge clk); chk("up4_c3", cnt_q, 1); chk("up4_w3", wrap, 0);
    @(negedge clk); chk("up4_c4", cnt_q, 2); chk("up4_done", done, 1);
    wait_idle();

    // To 1, then down 3 through the wrap
    go(0, 1, 0);
    send(0, 3, 0);
    @(negedge clk); chk("dn3_c1", cnt_q, 0); chk("dn3_w1", wrap, 0);
    @(negedge clk); chk("dn3_c2", cnt_q, 7); chk("dn3_w2", wrap, 1);
    @(negedge clk); chk("dn3_c3", cnt_q, 6); chk("dn3_done", done, 1);
    wait_idle();

    // To 5, then len 0 and clear (dir/len ignored on clear)
    go(0, 1, 0);
    send(0, 0, 0);
    chk("len0_done", done, 1); chk("len0_cnt", cnt_q, 5); chk("len0_wrap", wrap, 0);
    @(negedge clk); chk("len0_ready", cmd_ready, 1);
    send(1, 7, 1);
    chk("clr_done", done, 1); chk("clr_cnt", cnt_q, 0); chk("clr_wrap", wrap, 0);
    @(negedge clk); chk("clr_ready", cmd_ready, 1);

    // Reset mid-RUN after the 4th step
    go(1, 2, 0);
    send(1, 10, 0);
    repeat (4) @(negedge clk);
    chk("rrun_c4", cnt_q, 6);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rrun_cnt", cnt_q, 0); chk("rrun_busy", busy, 0);
    chk("rrun_done", done, 0); chk("rrun_ready", cmd_ready, 1);

    // Reset in DONE
    send(1, 1, 0);
    @(negedge clk); chk("rdone_done", done, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rdone_done_off", done, 0); chk("rdone_ready", cmd_ready, 1);
    chk("rdone_cnt", cnt_q, 0);

    // cmd_valid held with changing len: only first IDLE cycle accepts
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1; cmd_dir = 1; cmd_clr = 0; cmd_len = LW'(len_tbl[i]);
      @(negedge clk);
      if (i == 1) chk("hold_ready_run", cmd_ready, 0);
      if (i == 2) chk("hold_done", done, 1);
      if (i == 3) chk("hold_ready_idle", cmd_ready, 1);
      if (i == 4) begin chk("hold_busy", busy, 1); chk("hold_cnt", cnt_q, 2); end
    end
    cmd_valid = 0;
    wait_idle();
    chk("hold_final", cnt_q, 5);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
